if_fetch: RTL and testbench
===========================

# if_fetch

Byte-serial Y86 instruction fetch stage, directly upstream of the decode stage. Owns the PC, reads instruction bytes one at a time from a byte-wide instruction memory port, and assembles each variable-length instruction into a 48-bit word. It presents the word together with its PC to decode over a valid/ready handshake. Accepts PC redirects from later stages and stops fetching after `halt`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous reset, active-low (asserted when 0).
- `mem_req_o` output 1: byte read request.
- `mem_addr_o` output 32: byte address; held stable while `mem_req_o`=1 and not acked.
- `mem_data_i` input 8: read data, valid in the cycle `mem_ack_i`=1.
- `mem_ack_i` input 1: read completes this cycle; may be combinational from `mem_req_o`.
- `redir_valid_i` input 1: redirect the PC.
- `redir_pc_i` input 32: new PC.
- `inst_o` output 48: assembled instruction.
- `pc_o` output 32: address of byte 0 of `inst_o`.
- `inst_valid_o` output 1: `inst_o`/`pc_o` valid.
- `id_ready_i` input 1: decode accepts this cycle.
- `inst_err_o` output 1: invalid icode; qualified by `inst_valid_o`.
- `halted_o` output 1: fetch stopped after `halt`/error.

## Operation
- States: FETCH (issue bytes), HOLD (instruction complete, awaiting accept), HALTED.
- Length from byte0[7:4] (icode): 0 halt, 1 nop, 9 ret → 1; 2 rrmovl/cmov, 6 opl, A pushl, B popl → 2; 7 jXX, 8 call → 5; 3 irmovl, 4 rmmovl, 5 mrmovl → 6; C–F → 1 with `inst_err_o`=1.
- Byte counter `cnt` (0..5) counts acked bytes; `mem_addr_o` = pc + cnt.
- Packing: byte0 → [47:40]; byte1 → [39:32]. 6-byte instructions: bytes 2..5 are little-endian in [31:0]. jXX/call: bytes 1..4 are little-endian in [31:0], and [39:32]=8'hFF. Unfetched fields are 0.
- When the last byte is acked, go to HOLD, assert `inst_valid_o`, `mem_req_o`=0.
- In HOLD, when `id_ready_i`=1: pc ← pc + length (32-bit wrap), cnt ← 0, then either:
  - → FETCH, or
  - → HALTED if icode=0 or `inst_err_o`.
- HALTED: `halted_o`=1, `mem_req_o`=0, `inst_valid_o`=0; leave only via redirect or reset.
- Redirect has highest priority in every state: pc ← `redir_pc_i`, cnt ← 0, `inst_valid_o` ← 0, state ← FETCH. A same-cycle `mem_ack_i` or `id_ready_i` is ignored. An abandoned memory request is permitted.

## Timing
- Reset values:
  - pc = `RESET_PC`, cnt = 0, state FETCH.
  - `mem_req_o` = 0, `inst_valid_o` = 0, `inst_err_o` = 0, `halted_o` = 0, `inst_o` = 0, `pc_o` = `RESET_PC`.
- `mem_req_o` rises in the first cycle after `rst` deasserts.
- Reset mid-fetch discards partial bytes immediately (asynchronous).
- With a combinational ack every cycle, an n-byte instruction acks in cycles 1..n and `inst_valid_o` is high in cycle n+1.
- Handshake: transfer occurs on an edge where `inst_valid_o` & `id_ready_i`. `inst_o`, `pc_o` and `inst_err_o` are stable while valid and not accepted.
- After a transfer, the next `mem_req_o` is asserted in the following cycle. Throughput is n+1 cycles per n-byte instruction.
- Wait states: `mem_req_o`/`mem_addr_o` held until ack; cnt advances only on ack.
- All outputs registered except `mem_addr_o` (pc + cnt).

## Configuration
- `FETCH_PREDICT_EN` defined: on acceptance of call (icode 8) or unconditional jmp (icode 7, ifun 0), next pc ← dest ([31:0]) instead of pc+5.
- `FETCH_PREDICT_EN` undefined: next pc is always pc + length; control flow changes only through redirect.

## Test plan
- Reset with `RESET_PC`=0x100, memory 0x10 0x00 (nop, halt), ack always, ready always:
  - `inst_o` 0x10_0000000000 @pc 0x100, then 0x00_0000000000 @0x101.
  - `halted_o`=1 and `mem_req_o`=0 afterwards.
- irmovl bytes 30 F3 78 56 34 12 at 0x0 → `inst_o`=0x30F3_12345678, `pc_o`=0, valid in cycle 7, next fetch address 0x6.
- call 80 00 02 00 00 at 0x10 → `inst_o`=0x80FF_00000200. Next pc is 0x200 with `FETCH_PREDICT_EN`, 0x15 without.
- `id_ready_i`=0 for 5 cycles on a valid opl (60 12) → outputs stable, `mem_req_o`=0; accepted on cycle 6; next addr pc+2.
- Redirect to 0x40 while cnt=3 of a 6-byte fetch, with ack the same cycle → partial discarded, next `mem_addr_o`=0x40, no valid output for the old instruction.
- Byte 0xE5 at 0x20 → `inst_err_o`=1 with valid; after accept `halted_o`=1; redirect to 0x0 resumes fetch.

Source files
------------

// File: rtl/if_fetch_if.sv
// if_fetch_if: bundle of the fetch stage's memory port, redirect input and
// decode-side handshake. The fetch stage takes the master view; the memory,
// redirect source and decode stage together take the slave view.
interface if_fetch_if;
  // byte-wide instruction memory port
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_i;
  logic        mem_ack_i;
  // PC redirect from later stages
  logic        redir_valid_i;
  logic [31:0] redir_pc_i;
  // instruction handoff to decode
  logic [47:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic        id_ready_i;
  logic        inst_err_o;
  logic        halted_o;

  modport master (
    output mem_req_o, mem_addr_o, inst_o, pc_o, inst_valid_o, inst_err_o, halted_o,
    input  mem_data_i, mem_ack_i, redir_valid_i, redir_pc_i, id_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, inst_o, pc_o, inst_valid_o, inst_err_o, halted_o,
    output mem_data_i, mem_ack_i, redir_valid_i, redir_pc_i, id_ready_i
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: byte-serial Y86 instruction fetch. Reads one byte per ack,
// assembles a 48-bit instruction word and hands it to decode over
// valid/ready. Stops after halt or an invalid icode until redirected.
// Optional feature macro: FETCH_PREDICT_EN -- when defined, an accepted call
// or unconditional jmp continues fetching at its destination.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  if_fetch_if.master  bus
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [2:0]  cnt, cnt_d;
  logic [47:0] inst, inst_d;
  logic        valid, valid_d;
  logic        err, err_d;
  logic        halted, halted_d;
  logic        req, req_d;

  logic [3:0]  icode;
  logic [2:0]  len;
  logic        last_byte;
  logic        stop;
  logic [31:0] next_pc;
  logic [7:0]  data;

  // Instruction length in bytes, decoded from the icode nibble.
  function automatic logic [2:0] inst_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: inst_len = 3'd2;
      4'h7, 4'h8:             inst_len = 3'd5;
      4'h3, 4'h4, 4'h5:       inst_len = 3'd6;
      default:                inst_len = 3'd1;  // halt, nop, ret, invalid C-F
    endcase
  endfunction

  assign data = bus.mem_data_i;

  // Byte 0 is still on the bus while it is being acked; afterwards the
  // captured copy in the instruction register is authoritative.
  assign icode     = (state == FETCH && cnt == 3'd0) ? data[7:4] : inst[47:44];
  assign len       = inst_len(icode);
  assign last_byte = (cnt + 3'd1 == len);
  assign stop      = (inst[47:44] == 4'h0) || err;

  // Sequential successor of the instruction sitting in HOLD.
  always_comb begin
    next_pc = pc + {29'd0, len};
`ifdef FETCH_PREDICT_EN
    if (inst[47:44] == 4'h8 || inst[47:40] == 8'h70) next_pc = inst[31:0];
`endif
  end

  assign bus.mem_addr_o   = pc + {29'd0, cnt};
  assign bus.mem_req_o    = req;
  assign bus.inst_o       = inst;
  assign bus.pc_o         = pc;
  assign bus.inst_valid_o = valid;
  assign bus.inst_err_o   = err;
  assign bus.halted_o     = halted;

  // State register; an asynchronous reset drops any partially fetched bytes.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      cnt    <= 3'd0;
      inst   <= 48'd0;
      valid  <= 1'b0;
      err    <= 1'b0;
      halted <= 1'b0;
      req    <= 1'b0;
    end else begin
      state  <= state_d;
      pc     <= pc_d;
      cnt    <= cnt_d;
      inst   <= inst_d;
      valid  <= valid_d;
      err    <= err_d;
      halted <= halted_d;
      req    <= req_d;
    end
  end

  // Next-state logic: redirect first, then per-state fetch/hold/halt behaviour.
  always_comb begin
    // NOTE: every target gets a hold value up front so no path infers a latch.
    state_d  = state;
    pc_d     = pc;
    cnt_d    = cnt;
    inst_d   = inst;
    valid_d  = valid;
    err_d    = err;
    halted_d = halted;
    req_d    = req;

    if (bus.redir_valid_i) begin
      state_d  = FETCH;
      pc_d     = bus.redir_pc_i;
      cnt_d    = 3'd0;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      req_d    = 1'b1;
    end else begin
      case (state)
        FETCH: begin
          req_d = 1'b1;
          if (req && bus.mem_ack_i) begin
            // jXX/call carry their 4-byte destination in bytes 1..4;
            // 6-byte forms carry rA/rB in byte 1 and the constant in bytes 2..5.
            case (cnt)
              3'd1: if (len == 3'd5) inst_d[7:0]   = data; else inst_d[39:32] = data;
              3'd2: if (len == 3'd5) inst_d[15:8]  = data; else inst_d[7:0]   = data;
              3'd3: if (len == 3'd5) inst_d[23:16] = data; else inst_d[15:8]  = data;
              3'd4: if (len == 3'd5) inst_d[31:24] = data; else inst_d[23:16] = data;
              3'd5: inst_d[31:24] = data;
              default: begin
                inst_d = {data, 40'd0};
                if (len == 3'd5) inst_d[39:32] = 8'hFF;
                err_d = (icode >= 4'hC);
              end
            endcase
            if (last_byte) begin
              state_d = HOLD;
              valid_d = 1'b1;
              req_d   = 1'b0;
            end else begin
              cnt_d = cnt + 3'd1;
            end
          end
        end
        HOLD: begin
          if (bus.id_ready_i) begin
            pc_d    = next_pc;
            cnt_d   = 3'd0;
            valid_d = 1'b0;
            if (stop) begin
              state_d  = HALTED;
              halted_d = 1'b1;
              req_d    = 1'b0;
            end else begin
              state_d = FETCH;
              req_d   = 1'b1;
            end
          end
        end
        HALTED: begin
          req_d = 1'b0;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenarios followed by a randomized run with wait
// states, decode back-pressure and redirects, all checked against a
// byte-array model of the program image.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  logic ack_en;
  bit   rand_mode;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] mem [0:4095];

  always #5 clk = ~clk;

  if_fetch_if bus ();

  // Memory acks in the same cycle as the request whenever ack_en is set.
  assign bus.mem_ack_i  = bus.mem_req_o & ack_en;
  assign bus.mem_data_i = mem[bus.mem_addr_o[11:0]];

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rand_mode) ack_en = ($urandom_range(0, 3) != 0);
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redir_valid_i = 1'b1;
    bus.redir_pc_i    = target;
    tick();
    bus.redir_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.inst_valid_o !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (bus.inst_valid_o !== 1'b1) check("valid_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- reference model over the program image ----------------
  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem[a[11:0]];
  endfunction

  function automatic int ref_len(input logic [7:0] b0);
    case (b0[7:4])
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 5;
      4'h3, 4'h4, 4'h5:       return 6;
      default:                return 1;
    endcase
  endfunction

  function automatic logic [47:0] ref_inst(input logic [31:0] pc);
    logic [7:0] b [6];
    for (int i = 0; i < 6; i++) b[i] = rd(pc + 32'(i));
    case (ref_len(b[0]))
      1:       return {b[0], 40'd0};
      2:       return {b[0], b[1], 32'd0};
      5:       return {b[0], 8'hFF, b[4], b[3], b[2], b[1]};
      default: return {b[0], b[1], b[5], b[4], b[3], b[2]};
    endcase
  endfunction

  function automatic logic ref_err(input logic [31:0] pc);
    logic [7:0] b0;
    b0 = rd(pc);
    return b0[7:4] >= 4'hC;
  endfunction

  function automatic logic ref_stop(input logic [31:0] pc);
    logic [7:0] b0;
    b0 = rd(pc);
    return (b0[7:4] == 4'h0) || (b0[7:4] >= 4'hC);
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] pc);
    logic [7:0]  b0;
    logic [47:0] w;
    b0 = rd(pc);
    w  = ref_inst(pc);
`ifdef FETCH_PREDICT_EN
    if (b0[7:4] == 4'h8 || b0 == 8'h70) return w[31:0];
`endif
    return pc + 32'(ref_len(b0));
  endfunction

  initial begin
    int          c;
    logic [31:0] pc_m;
    logic [47:0] held;

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[32'h100] = 8'h10; mem[32'h101] = 8'h00;
    mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h78;
    mem[3] = 8'h56; mem[4] = 8'h34; mem[5] = 8'h12;
    mem[6] = 8'h10;
    mem[16] = 8'h80; mem[17] = 8'h00; mem[18] = 8'h02; mem[19] = 8'h00; mem[20] = 8'h00;
    mem[21] = 8'h10; mem[32'h200] = 8'h10;
    mem[32'h20] = 8'hE5;
    mem[32'h30] = 8'h60; mem[32'h31] = 8'h12;
    mem[32'h40] = 8'h10; mem[32'h41] = 8'h00;

    rst = 1'b0; ack_en = 1'b1; rand_mode = 1'b0;
    bus.redir_valid_i = 1'b0; bus.redir_pc_i = 32'd0; bus.id_ready_i = 1'b1;

    // Reset values.
    tick(); tick();
    check("rst_req",    bus.mem_req_o,    1'b0);
    check("rst_valid",  bus.inst_valid_o, 1'b0);
    check("rst_err",    bus.inst_err_o,   1'b0);
    check("rst_halted", bus.halted_o,     1'b0);
    check("rst_inst",   bus.inst_o,       48'd0);
    check("rst_pc",     bus.pc_o,         RST_PC);
    rst = 1'b1;

    // nop, halt from RESET_PC.
    wait_valid(c);
    check("nop_cycle", c, 2);
    check("nop_inst",  bus.inst_o, 48'h10_0000000000);
    check("nop_pc",    bus.pc_o,   32'h100);
    tick();
    wait_valid(c);
    check("halt_inst", bus.inst_o, 48'h00_0000000000);
    check("halt_pc",   bus.pc_o,   32'h101);
    tick();
    check("halted",        bus.halted_o,     1'b1);
    check("halted_req",    bus.mem_req_o,    1'b0);
    check("halted_valid",  bus.inst_valid_o, 1'b0);
    tick();
    check("halted_req2",   bus.mem_req_o,    1'b0);

    // irmovl at 0x0.
    redirect(32'h0);
    check("irm_req",  bus.mem_req_o,  1'b1);
    check("irm_addr", bus.mem_addr_o, 32'h0);
    wait_valid(c);
    check("irm_cycle", c, 6);
    check("irm_inst",  bus.inst_o,     48'h30F3_12345678);
    check("irm_pc",    bus.pc_o,       32'h0);
    check("irm_err",   bus.inst_err_o, 1'b0);
    tick();
    check("irm_next_req",  bus.mem_req_o,  1'b1);
    check("irm_next_addr", bus.mem_addr_o, 32'h6);

    // call at 0x10.
    redirect(32'h10);
    wait_valid(c);
    check("call_inst", bus.inst_o, 48'h80FF_00000200);
    check("call_pc",   bus.pc_o,   32'h10);
    tick();
`ifdef FETCH_PREDICT_EN
    check("call_next", bus.mem_addr_o, 32'h200);
`else
    check("call_next", bus.mem_addr_o, 32'h15);
`endif

    // opl held by decode back-pressure for 5 cycles.
    bus.id_ready_i = 1'b0;
    redirect(32'h30);
    wait_valid(c);
    check("opl_inst", bus.inst_o, 48'h6012_00000000);
    held = bus.inst_o;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("opl_hold_valid", bus.inst_valid_o, 1'b1);
      check("opl_hold_inst",  bus.inst_o,       held);
      check("opl_hold_pc",    bus.pc_o,         32'h30);
      check("opl_hold_err",   bus.inst_err_o,   1'b0);
      check("opl_hold_req",   bus.mem_req_o,    1'b0);
    end
    bus.id_ready_i = 1'b1;
    tick();
    check("opl_next_req",  bus.mem_req_o,  1'b1);
    check("opl_next_addr", bus.mem_addr_o, 32'h32);

    // Redirect at cnt=3 of irmovl with a same-cycle ack.
    redirect(32'h0);
    tick(); tick(); tick();
    check("mid_addr", bus.mem_addr_o, 32'h3);
    bus.redir_valid_i = 1'b1;
    bus.redir_pc_i    = 32'h40;
    tick();
    bus.redir_valid_i = 1'b0;
    check("mid_redir_addr",  bus.mem_addr_o,   32'h40);
    check("mid_redir_req",   bus.mem_req_o,    1'b1);
    check("mid_redir_valid", bus.inst_valid_o, 1'b0);
    wait_valid(c);
    check("mid_new_pc",   bus.pc_o,   32'h40);
    check("mid_new_inst", bus.inst_o, 48'h10_0000000000);
    tick();
    wait_valid(c);
    check("mid_halt_pc", bus.pc_o, 32'h41);
    tick();

    // Invalid icode halts fetch; redirect resumes it.
    redirect(32'h20);
    wait_valid(c);
    check("bad_err",  bus.inst_err_o, 1'b1);
    check("bad_inst", bus.inst_o,     48'hE5_0000000000);
    check("bad_pc",   bus.pc_o,       32'h20);
    tick();
    check("bad_halted", bus.halted_o,     1'b1);
    check("bad_req",    bus.mem_req_o,    1'b0);
    check("bad_valid",  bus.inst_valid_o, 1'b0);
    redirect(32'h0);
    check("resume_halted", bus.halted_o,   1'b0);
    check("resume_req",    bus.mem_req_o,  1'b1);
    check("resume_addr",   bus.mem_addr_o, 32'h0);

    // Asynchronous reset mid-fetch.
    tick();
    rst = 1'b0;
    #1;
    check("arst_req",   bus.mem_req_o,    1'b0);
    check("arst_valid", bus.inst_valid_o, 1'b0);
    check("arst_pc",    bus.pc_o,         RST_PC);
    check("arst_inst",  bus.inst_o,       48'd0);
    #1 rst = 1'b1;
    tick();
    check("arst_resume_addr", bus.mem_addr_o, RST_PC);
    check("arst_resume_req",  bus.mem_req_o,  1'b1);

    // Randomized program image, wait states, back-pressure and redirects.
    for (int i = 12'h400; i < 4096; i++) mem[i] = 8'($urandom);
    rand_mode = 1'b1;
    bus.id_ready_i = 1'b0;
    pc_m = 32'h400 + 32'($urandom_range(0, 32'hBFF));
    redirect(pc_m);
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 3)) tick();
        pc_m = $urandom;
        redirect(pc_m);
      end
      wait_valid(c);
      check("rnd_pc",   bus.pc_o,       pc_m);
      check("rnd_inst", bus.inst_o,     ref_inst(pc_m));
      check("rnd_err",  bus.inst_err_o, ref_err(pc_m));
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("rnd_hold_valid", bus.inst_valid_o, 1'b1);
        check("rnd_hold_inst",  bus.inst_o,       ref_inst(pc_m));
      end
      bus.id_ready_i = 1'b1;
      tick();
      bus.id_ready_i = 1'b0;
      if (ref_stop(pc_m)) begin
        check("rnd_halted", bus.halted_o, 1'b1);
        pc_m = $urandom;
        redirect(pc_m);
      end else begin
        check("rnd_running", bus.halted_o, 1'b0);
        pc_m = ref_next(pc_m);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
